rx_deframer: RTL

Receive-side serial-in/parallel-out stage of the UART receiver. Detects a frame on the oversampled serial line, samples every bit at its centre, and presents the separated start, data, parity and stop fields with a one-cycle `recieved_flag` strobe. The error checker consumes all of these outputs directly, so their encodings follow that checker's conventions.

---
 rtl/rx_deframer_if.sv | 47 ++++
 rtl/rx_deframer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/rx_deframer_if.sv
`default_nettype none
// ============================================================================
//  Module      : rx_deframer_if
//  Description : Bundle of the UART receive deframer signals.
//                Line side : baud_tick, serial_in, parity_type (into deframer)
//                Field side: raw_data, parity_bit, start_bit, stop_bit,
//                            recieved_flag, active (out of deframer)
//                master = the deframer itself, slave = the environment that
//                drives the line and consumes the received fields.
//  Revision    : 1.0  initial release
// ============================================================================
interface rx_deframer_if;
    logic       baud_tick;
    logic       serial_in;
    logic [1:0] parity_type;
    logic [7:0] raw_data;
    logic       parity_bit;
    logic       start_bit;
    logic       stop_bit;
    logic       recieved_flag;
    logic       active;

    modport master (
        input  baud_tick,
        input  serial_in,
        input  parity_type,
        output raw_data,
        output parity_bit,
        output start_bit,
        output stop_bit,
        output recieved_flag,
        output active
    );

    modport slave (
        output baud_tick,
        output serial_in,
        output parity_type,
        input  raw_data,
        input  parity_bit,
        input  start_bit,
        input  stop_bit,
        input  recieved_flag,
        input  active
    );
endinterface
`default_nettype wire

// File: rtl/rx_deframer.sv
`default_nettype none
// ============================================================================
//  Module      : rx_deframer
//  Description : UART receive serial-to-parallel stage. 16x oversampled line,
//                8 data bits LSB first, optional odd/even parity, 1 stop bit.
//                Samples each bit at its centre and presents start, data,
//                parity and stop fields with a one-cycle recieved_flag strobe.
//  Ports       : clock, reset_n (async, active low)
//                bus.baud_tick   - 16 enables per bit period
//                bus.serial_in   - asynchronous line, idle high
//                bus.parity_type - 01 odd, 10 even, 00/11 no parity slot
//                bus.raw_data / parity_bit / start_bit / stop_bit - fields
//                bus.recieved_flag - fields valid strobe
//                bus.active      - frame in progress
//  Revision    : 1.0  initial release
// ============================================================================
module rx_deframer (
    input  wire logic     clock,
    input  wire logic     reset_n,
    rx_deframer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Start bit is sampled half a bit after detection, every later field a
    // full bit after the previous sample.
    localparam logic [3:0] c_mid_tick  = 4'd7;
    localparam logic [3:0] c_last_tick = 4'd15;
    localparam logic [2:0] c_last_bit  = 3'd7;

    state_t     state_q, state_d;
    logic       sync1_q, sync2_q;
    logic       rx_s;
    logic [3:0] tick_cnt_q, tick_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       armed_q, armed_d;
    logic [1:0] ptype_q, ptype_d;
    logic [7:0] shift_q, shift_d;
    logic       start_q, start_d;
    logic       par_q, par_d;
    logic       has_parity;

    // Output registers are separate from the shift state so the fields
    // stay stable while the next frame is being received.
    logic [7:0] raw_data_q, raw_data_d;
    logic       parity_bit_q, parity_bit_d;
    logic       start_bit_q, start_bit_d;
    logic       stop_bit_q, stop_bit_d;
    logic       flag_q, flag_d;

    assign rx_s       = sync2_q;
    assign has_parity = (ptype_q == 2'b01) || (ptype_q == 2'b10);

    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        armed_d      = armed_q;
        ptype_d      = ptype_q;
        shift_d      = shift_q;
        start_d      = start_q;
        par_d        = par_q;
        raw_data_d   = raw_data_q;
        parity_bit_d = parity_bit_q;
        start_bit_d  = start_bit_q;
        stop_bit_d   = stop_bit_q;
        flag_d       = 1'b0;

        if (bus.baud_tick) begin
            case (state_q)
                S_IDLE: begin
                    // A falling edge only counts once the line has been seen
                    // idle high; this stops a held-low line from retriggering.
                    if (rx_s) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        armed_d    = 1'b0;
                        ptype_d    = bus.parity_type;
                        tick_cnt_d = 4'd0;
                        bit_cnt_d  = 3'd0;
                        state_d    = S_START;
                    end
                end

                S_START: begin
                    if (tick_cnt_q == c_mid_tick) begin
                        start_d    = rx_s;
                        tick_cnt_d = 4'd0;
                        state_d    = S_DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end

                S_DATA: begin
                    if (tick_cnt_q == c_last_tick) begin
                        shift_d[bit_cnt_q] = rx_s;
                        tick_cnt_d         = 4'd0;
                        if (bit_cnt_q == c_last_bit) begin
                            bit_cnt_d = 3'd0;
                            state_d   = has_parity ? S_PARITY : S_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end

                S_PARITY: begin
                    if (tick_cnt_q == c_last_tick) begin
                        par_d      = rx_s;
                        tick_cnt_d = 4'd0;
                        state_d    = S_STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end

                S_STOP: begin
                    if (tick_cnt_q == c_last_tick) begin
                        raw_data_d   = shift_q;
                        // No parity slot: report 1 so the checker sees no error.
                        parity_bit_d = has_parity ? par_q : 1'b1;
                        start_bit_d  = start_q;
                        stop_bit_d   = rx_s;
                        flag_d       = 1'b1;
                        tick_cnt_d   = 4'd0;
                        armed_d      = 1'b0;
                        state_d      = S_IDLE;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end

                default: begin
                    state_d    = S_IDLE;
                    tick_cnt_d = 4'd0;
                    armed_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            state_q      <= S_IDLE;
            tick_cnt_q   <= 4'd0;
            bit_cnt_q    <= 3'd0;
            armed_q      <= 1'b0;
            ptype_q      <= 2'b00;
            shift_q      <= 8'h00;
            start_q      <= 1'b0;
            par_q        <= 1'b1;
            raw_data_q   <= 8'h00;
            parity_bit_q <= 1'b1;
            start_bit_q  <= 1'b0;
            stop_bit_q   <= 1'b1;
            flag_q       <= 1'b0;
        end else begin
            sync1_q      <= bus.serial_in;
            sync2_q      <= sync1_q;
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            armed_q      <= armed_d;
            ptype_q      <= ptype_d;
            shift_q      <= shift_d;
            start_q      <= start_d;
            par_q        <= par_d;
            raw_data_q   <= raw_data_d;
            parity_bit_q <= parity_bit_d;
            start_bit_q  <= start_bit_d;
            stop_bit_q   <= stop_bit_d;
            flag_q       <= flag_d;
        end
    end

    assign bus.raw_data      = raw_data_q;
    assign bus.parity_bit    = parity_bit_q;
    assign bus.start_bit     = start_bit_q;
    assign bus.stop_bit      = stop_bit_q;
    assign bus.recieved_flag = flag_q;
    assign bus.active        = (state_q != S_IDLE);

endmodule
`default_nettype wire
